// File: rtl/xor_hash_stream.sv
// Streaming XOR digest: folds keep-masked beats into a HASH_W-bit hash per packet.
// Optional byte counter on out_len when XOR_HASH_BYTECNT_EN is defined.
module xor_hash_stream #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HASH_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [HASH_W-1:0]   out_hash
`ifdef XOR_HASH_BYTECNT_EN
  ,
  output logic [LEN_W-1:0]    out_len
`endif
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CHUNKS = DATA_W / HASH_W;

  // Elaboration-time parameter sanity checks.
  if ((DATA_W % HASH_W) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of HASH_W");
  end
  if (HASH_W != 8 && HASH_W != 16 && HASH_W != 32) begin : g_bad_hash_w
    $error("HASH_W must be 8, 16 or 32");
  end
  if (LEN_W == 0) begin : g_bad_len_w
    $error("LEN_W must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state, state_d;
  logic [HASH_W-1:0]   acc, acc_d;
  logic [HASH_W-1:0]   hash_d;
  logic                valid_d;
  logic                ready_d;
  logic [DATA_W-1:0]   masked;
  logic [HASH_W-1:0]   fold;
  logic                accept;

  assign accept = in_valid & in_ready;

  // Zero every byte whose keep bit is clear.
  always_comb begin
    masked = '0;
    for (int k = 0; k < int'(KEEP_W); k++) begin
      masked[8*k +: 8] = in_keep[k] ? in_data[8*k +: 8] : 8'h00;
    end
  end

  always_comb begin
    fold = '0;
    for (int c = 0; c < int'(CHUNKS); c++) begin
      fold = fold ^ masked[c*HASH_W +: HASH_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    hash_d  = out_hash;
    valid_d = out_valid;
    ready_d = in_ready;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            hash_d  = acc ^ fold;
            acc_d   = '0;
            state_d = DONE;
            valid_d = 1'b1;
            ready_d = 1'b0;
          end else begin
            acc_d   = acc ^ fold;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      out_hash  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      out_hash  <= hash_d;
      out_valid <= valid_d;
      in_ready  <= ready_d;
    end
  end

`ifdef XOR_HASH_BYTECNT_EN
  localparam int unsigned PC_W  = $clog2(KEEP_W + 1);
  localparam int unsigned SUM_W = ((LEN_W > PC_W) ? LEN_W : PC_W) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [LEN_W-1:0] cnt, cnt_d, len_d, cnt_sat;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pc = '0;
    for (int k = 0; k < int'(KEEP_W); k++) begin
      pc = pc + PC_W'(in_keep[k]);
    end
  end

  // Saturating add; the last beat's bytes are included in the captured length.
  always_comb begin
    sum     = SUM_W'(cnt) + SUM_W'(pc);
    cnt_sat = (sum > SUM_W'(LEN_MAX)) ? LEN_MAX : LEN_W'(sum);
    cnt_d   = cnt;
    len_d   = out_len;
    if (accept) begin
      if (in_last) begin
        len_d = cnt_sat;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      out_len <= '0;
    end else begin
      cnt     <= cnt_d;
      out_len <= len_d;
    end
  end
`endif

endmodule

// File: tb/tb_xor_hash_stream.sv
// Directed bench for xor_hash_stream (DATA_W=32, HASH_W=8); checks out_len when
// XOR_HASH_BYTECNT_EN is defined.
module tb_xor_hash_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_hash;
`ifdef XOR_HASH_BYTECNT_EN
  logic [15:0] out_len;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_hash;
  logic [1:0]  s_out_len;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_hash_stream #(.DATA_W(32), .HASH_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash)
`ifdef XOR_HASH_BYTECNT_EN
    , .out_len(out_len)
`endif
  );

`ifdef XOR_HASH_BYTECNT_EN
  xor_hash_stream #(.DATA_W(32), .HASH_W(8), .LEN_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_hash(s_out_hash),
    .out_len(s_out_len)
  );
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [7:0]  exp_hash;
    logic [15:0] exp_len;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat just after an edge; it must be accepted on the next edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    check("in_ready_before_beat", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{32'h01020304, 4'b1111, 1'b1, 8'h04, 16'd4};
    vecs[1] = '{32'h11223344, 4'b1111, 1'b0, 8'h00, 16'd0};
    vecs[2] = '{32'hFFFFFFFF, 4'b1111, 1'b1, 8'h44, 16'd8};
    vecs[3] = '{32'hAABBCCDD, 4'b0011, 1'b1, 8'h11, 16'd2};
    vecs[4] = '{32'hDEADBEEF, 4'b0000, 1'b1, 8'h00, 16'd0};
    vecs[5] = '{32'h80000000, 4'b1000, 1'b1, 8'h80, 16'd1};
    vecs[6] = '{32'h000000A5, 4'b1111, 1'b0, 8'h00, 16'd0};
    vecs[7] = '{32'h0000005A, 4'b1111, 1'b0, 8'h00, 16'd0};
    vecs[8] = '{32'h12345678, 4'b0101, 1'b1, 8'hB3, 16'd10};
    vecs[9] = '{32'h00110000, 4'b1100, 1'b1, 8'h11, 16'd2};

    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_hash", 32'(out_hash), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef XOR_HASH_BYTECNT_EN
    check("reset_out_len", 32'(out_len), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_out_hash_zero", 32'(out_hash), 32'd0);

    // Table: out_ready held high, so DONE lasts exactly one cycle.
    for (int i = 0; i < 10; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].last);
      if (vecs[i].last) begin
        check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_out_hash", i), 32'(out_hash), 32'(vecs[i].exp_hash));
        check($sformatf("vec%0d_no_bypass", i), 32'(in_ready), 32'd0);
`ifdef XOR_HASH_BYTECNT_EN
        check($sformatf("vec%0d_out_len", i), 32'(out_len), 32'(vecs[i].exp_len));
`endif
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_drain_valid", i), 32'(out_valid), 32'd0);
        check($sformatf("vec%0d_drain_ready", i), 32'(in_ready), 32'd1);
      end else begin
        check($sformatf("vec%0d_mid_valid", i), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: digest held, offered beat not consumed.
    out_ready = 1'b0;
    send_beat(32'h01020304, 4'b1111, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h000000FF;
    in_keep  = 4'b1111;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_out_hash", c), 32'(out_hash), 32'h04);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send_beat(32'h00000001, 4'b1111, 1'b1);
    check("bp_nothing_consumed", 32'(out_hash), 32'h01);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-packet discards the partial accumulation.
    send_beat(32'h000000FF, 4'b1111, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_hash", 32'(out_hash), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    send_beat(32'h00000001, 4'b1111, 1'b1);
    check("rst_discard_valid", 32'(out_valid), 32'd1);
    check("rst_discard_hash", 32'(out_hash), 32'h01);
    @(posedge clk);
    #1;

`ifdef XOR_HASH_BYTECNT_EN
    // Byte count: two beats sum, and the 2-bit counter saturates.
    send_beat(32'h00000000, 4'b1111, 1'b0);
    send_beat(32'h00000000, 4'b0011, 1'b1);
    check("len_two_beats", 32'(out_len), 32'd6);
    @(posedge clk);
    #1;
    send_beat(32'h00000000, 4'b1111, 1'b0);
    send_beat(32'h00000000, 4'b1111, 1'b0);
    send_beat(32'h00000000, 4'b1111, 1'b1);
    check("len_sat_valid", 32'(s_out_valid), 32'd1);
    check("len_saturated", 32'(s_out_len), 32'd3);
    check("len_wide_twelve", 32'(out_len), 32'd12);
    @(posedge clk);
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
